// File: rtl/tron_pkg.sv
// Shared keyboard and game-state definitions for the Tron datapath.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package tron_pkg;

    // USB HID keycodes used by the game
    localparam logic [7:0] KC_NONE  = 8'h00;
    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;

    // Bike heading; reversing a heading flips bit 1
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    // Game state encoding, shared with the game state machine
    localparam logic [2:0] GS_MENU          = 3'd0;
    localparam logic [2:0] GS_ROUND_PAUSED  = 3'd1;
    localparam logic [2:0] GS_ROUND_STARTED = 3'd2;
    localparam logic [2:0] GS_BLUE_WINS     = 3'd3;
    localparam logic [2:0] GS_RED_WINS      = 3'd4;

    // Key tracking FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_PRESSED,
        ST_REPEATING
    } key_state_t;

    // A decoded direction key: hit says the code belongs to this player
    typedef struct packed {
        logic hit;
        dir_t dir;
    } dir_cmd_t;

    function automatic logic is_up_key(input logic [7:0] kc);
        return (kc == KC_W) || (kc == KC_UP);
    endfunction

    function automatic logic is_down_key(input logic [7:0] kc);
        return (kc == KC_S) || (kc == KC_DOWN);
    endfunction

    function automatic dir_cmd_t blue_cmd(input logic [7:0] kc);
        dir_cmd_t c;
        c = '{hit: 1'b1, dir: DIR_UP};
        case (kc)
            KC_W:    c.dir = DIR_UP;
            KC_D:    c.dir = DIR_RIGHT;
            KC_S:    c.dir = DIR_DOWN;
            KC_A:    c.dir = DIR_LEFT;
            default: c.hit = 1'b0;
        endcase
        return c;
    endfunction

    function automatic dir_cmd_t red_cmd(input logic [7:0] kc);
        dir_cmd_t c;
        c = '{hit: 1'b1, dir: DIR_UP};
        case (kc)
            KC_UP:    c.dir = DIR_UP;
            KC_RIGHT: c.dir = DIR_RIGHT;
            KC_DOWN:  c.dir = DIR_DOWN;
            KC_LEFT:  c.dir = DIR_LEFT;
            default:  c.hit = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Registers the raw keycode and accepts a new code once it has been stable long enough.
// Latency: o_press is asserted combinationally at the edge STABLE_CYCLES after kc_q first shows the code.
// Backpressure: none; any code change restarts the stability window.
module key_debounce
    import tron_pkg::*;
#(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = 25
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_keycode,
    output logic             o_start,
    output logic             o_press,
    output logic             o_release,
    output logic [7:0]       o_code,
    output logic [7:0]       o_accepted
);

    // The accepting cycle is the one whose increment would bring the counter
    // to STABLE_CYCLES-1, so the press lands exactly STABLE_CYCLES edges after
    // the first cycle kc_q showed the code.
    localparam logic [CNT_W-1:0] ACCEPT_CNT = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [7:0]       r_kc_q;
    logic [7:0]       r_cand;
    logic [7:0]       r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             w_stable_done;

    assign w_stable_done = r_busy && (r_kc_q == r_cand) && (r_cnt == ACCEPT_CNT);
    assign o_start       = !r_busy && (r_kc_q != r_acc);
    assign o_press       = w_stable_done && (r_cand != KC_NONE);
    assign o_release     = w_stable_done && (r_cand == KC_NONE);
    assign o_code        = r_cand;
    assign o_accepted    = r_acc;

    // Single input register; everything downstream looks only at kc_q
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_kc_q <= KC_NONE;
        else       r_kc_q <= i_keycode;
    end

    // Candidate tracking and stability counting
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cand <= KC_NONE;
            r_acc  <= KC_NONE;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (o_start) begin
            r_cand <= r_kc_q;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (r_kc_q != r_cand) begin
                r_cand <= r_kc_q;
                r_cnt  <= '0;
            end else if (w_stable_done) begin
                r_acc  <= r_cand;
                r_cnt  <= '0;
                r_busy <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/key_event_decoder.sv
// Turns debounced keycodes into one-cycle press events, menu auto-repeat and filtered bike headings.
// Latency: press outputs register STABLE_CYCLES+1 edges after the keycode input changes.
// Backpressure: none; events are strobes and downstream must sample them every cycle.
module key_event_decoder
    import tron_pkg::*;
#(
    parameter int         STABLE_CYCLES = 500000,
    parameter int         REPEAT_DELAY  = 25000000,
    parameter int         REPEAT_PERIOD = 5000000,
    parameter logic [1:0] BLUE_INIT_DIR = 2'b01,
    parameter logic [1:0] RED_INIT_DIR  = 2'b11,
    parameter int         CNT_W         = 25
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [2:0] Game_State,
    output logic [7:0] keycode_out,
    output logic       enter_pulse,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic [1:0] blue_dir,
    output logic       blue_dir_valid,
    output logic [1:0] red_dir,
    output logic       red_dir_valid
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             w_start;
    logic             w_press;
    logic             w_release;
    logic [7:0]       w_code;
    logic [7:0]       w_acc;

    key_state_t       r_state;
    key_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_cnt_nxt;
    logic             w_repeat;

    dir_cmd_t         w_blue_cmd;
    dir_cmd_t         w_red_cmd;
    logic             w_blue_take;
    logic             w_red_take;

    logic [7:0]       r_keycode_out;
    logic             r_enter;
    logic             r_up;
    logic             r_down;
    logic [1:0]       r_blue_dir;
    logic             r_blue_vld;
    logic [1:0]       r_red_dir;
    logic             r_red_vld;

    key_debounce #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_debounce (
        .i_clk      (Clk),
        .i_rst      (Reset),
        .i_keycode  (keycode),
        .o_start    (w_start),
        .o_press    (w_press),
        .o_release  (w_release),
        .o_code     (w_code),
        .o_accepted (w_acc)
    );

    // Key FSM state and repeat counter registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_rep_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rep_cnt <= w_rep_cnt_nxt;
        end
    end

    // Next state and auto-repeat timing; a key change always wins over a repeat
    always_comb begin
        w_state_nxt   = r_state;
        w_rep_cnt_nxt = r_rep_cnt;
        w_repeat      = 1'b0;
        case (r_state)
            ST_IDLE, ST_HELD: begin
                if (w_start) w_state_nxt = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (w_press) begin
                    w_state_nxt   = (is_up_key(w_code) || is_down_key(w_code)) ? ST_PRESSED : ST_HELD;
                    w_rep_cnt_nxt = '0;
                end else if (w_release) begin
                    w_state_nxt   = ST_IDLE;
                end
            end
            ST_PRESSED: begin
                if (w_start) begin
                    w_state_nxt   = ST_DEBOUNCE;
                end else if (r_rep_cnt == DELAY_LAST) begin
                    w_repeat      = 1'b1;
                    w_state_nxt   = ST_REPEATING;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + CNT_ONE;
                end
            end
            ST_REPEATING: begin
                if (w_start) begin
                    w_state_nxt   = ST_DEBOUNCE;
                end else if (r_rep_cnt == PERIOD_LAST) begin
                    w_repeat      = 1'b1;
                    w_rep_cnt_nxt = '0;
                end else begin
                    w_rep_cnt_nxt = r_rep_cnt + CNT_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Direction requests that are neither a no-op nor a 180-degree turn
    assign w_blue_cmd  = blue_cmd(w_code);
    assign w_red_cmd   = red_cmd(w_code);
    assign w_blue_take = w_press && w_blue_cmd.hit
                         && (w_blue_cmd.dir != r_blue_dir)
                         && (w_blue_cmd.dir != (r_blue_dir ^ 2'b10));
    assign w_red_take  = w_press && w_red_cmd.hit
                         && (w_red_cmd.dir != r_red_dir)
                         && (w_red_cmd.dir != (r_red_dir ^ 2'b10));

    // Press strobes; only up/down also fire on auto-repeat
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_keycode_out <= KC_NONE;
            r_enter       <= 1'b0;
            r_up          <= 1'b0;
            r_down        <= 1'b0;
        end else begin
            r_keycode_out <= w_press ? w_code : KC_NONE;
            r_enter       <= w_press && (w_code == KC_ENTER);
            r_up          <= (w_press && is_up_key(w_code)) || (w_repeat && is_up_key(w_acc));
            r_down        <= (w_press && is_down_key(w_code)) || (w_repeat && is_down_key(w_acc));
        end
    end

    // Headings follow presses only during a running round, else sit at their start values
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_blue_dir <= BLUE_INIT_DIR;
            r_blue_vld <= 1'b0;
            r_red_dir  <= RED_INIT_DIR;
            r_red_vld  <= 1'b0;
        end else if (Game_State != GS_ROUND_STARTED) begin
            r_blue_dir <= BLUE_INIT_DIR;
            r_blue_vld <= 1'b0;
            r_red_dir  <= RED_INIT_DIR;
            r_red_vld  <= 1'b0;
        end else begin
            r_blue_vld <= w_blue_take;
            r_red_vld  <= w_red_take;
            if (w_blue_take) r_blue_dir <= w_blue_cmd.dir;
            if (w_red_take)  r_red_dir  <= w_red_cmd.dir;
        end
    end

    assign keycode_out    = r_keycode_out;
    assign enter_pulse    = r_enter;
    assign up_pulse       = r_up;
    assign down_pulse     = r_down;
    assign blue_dir       = r_blue_dir;
    assign blue_dir_valid = r_blue_vld;
    assign red_dir        = r_red_dir;
    assign red_dir_valid  = r_red_vld;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: directed scenarios then random key sequences against a reference model.
// Latency: model predicts every output after each clock edge.
// Backpressure: none.
module tb_key_event_decoder;

    localparam int S  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode;
    logic [2:0] Game_State;
    logic [7:0] keycode_out;
    logic       enter_pulse, up_pulse, down_pulse;
    logic [1:0] blue_dir, red_dir;
    logic       blue_dir_valid, red_dir_valid;

    always #5 Clk = ~Clk;

    key_event_decoder #(
        .STABLE_CYCLES (S),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .BLUE_INIT_DIR (2'b01),
        .RED_INIT_DIR  (2'b11),
        .CNT_W         (25)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .keycode        (keycode),
        .Game_State     (Game_State),
        .keycode_out    (keycode_out),
        .enter_pulse    (enter_pulse),
        .up_pulse       (up_pulse),
        .down_pulse     (down_pulse),
        .blue_dir       (blue_dir),
        .blue_dir_valid (blue_dir_valid),
        .red_dir        (red_dir),
        .red_dir_valid  (red_dir_valid)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: a key press is the moment the registered code has
    // been seen unchanged for exactly S edges; repeats are timed from the press.
    logic [7:0] m_prev;
    logic [7:0] m_run_val;
    int         m_run;
    bit         m_rep_on;
    logic [7:0] m_rep_code;
    int         m_rep_t;
    logic [1:0] m_blue, m_red;

    // Observation counters for directed scenarios
    int n_enter, n_up, n_kc, n_bvalid, n_rvalid, step_idx, first_up;

    logic [7:0] kc_tab [11] = '{8'h00, 8'h28, 8'h1A, 8'h16, 8'h52, 8'h51,
                                8'h04, 8'h07, 8'h4F, 8'h50, 8'h33};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_cnt(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] blue_of(input logic [7:0] kc);
        case (kc)
            8'h1A:   return 3'b100;
            8'h07:   return 3'b101;
            8'h16:   return 3'b110;
            8'h04:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] red_of(input logic [7:0] kc);
        case (kc)
            8'h52:   return 3'b100;
            8'h4F:   return 3'b101;
            8'h51:   return 3'b110;
            8'h50:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit is_up(input logic [7:0] kc);
        return (kc == 8'h1A) || (kc == 8'h52);
    endfunction

    function automatic bit is_down(input logic [7:0] kc);
        return (kc == 8'h16) || (kc == 8'h51);
    endfunction

    task automatic model_reset();
        m_prev    = 8'h00;
        m_run_val = 8'h00;
        m_run     = S + 1;
        m_rep_on  = 1'b0;
        m_rep_code = 8'h00;
        m_rep_t   = 0;
        m_blue    = 2'b01;
        m_red     = 2'b11;
    endtask

    task automatic zero_counts();
        n_enter = 0; n_up = 0; n_kc = 0; n_bvalid = 0; n_rvalid = 0;
        step_idx = 0; first_up = -1;
    endtask

    // Drive one cycle of input, advance the model by one edge, compare all outputs
    task automatic step(input logic [7:0] kc, input logic [2:0] gs);
        logic [7:0] v;
        bit         press, rep_fire;
        logic [7:0] e_kc;
        logic       e_enter, e_up, e_down, e_bv, e_rv;
        logic [2:0] bc, rc;
        keycode    = kc;
        Game_State = gs;
        @(posedge Clk);
        #1;
        v      = m_prev;
        m_prev = kc;
        if (v == m_run_val) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run_val = v;
            m_run     = 1;
        end
        press    = (m_run == S) && (v != 8'h00);
        rep_fire = 1'b0;
        if (m_rep_on) begin
            if (v != m_rep_code) m_rep_on = 1'b0;
            else begin
                m_rep_t++;
                if (m_rep_t == RD || (m_rep_t > RD && (m_rep_t - RD) % RP == 0)) rep_fire = 1'b1;
            end
        end
        if (press) begin
            if (is_up(v) || is_down(v)) begin
                m_rep_on = 1'b1; m_rep_code = v; m_rep_t = 0;
            end else m_rep_on = 1'b0;
        end
        e_kc    = press ? v : 8'h00;
        e_enter = press && (v == 8'h28);
        e_up    = (press && is_up(v)) || (rep_fire && is_up(m_rep_code));
        e_down  = (press && is_down(v)) || (rep_fire && is_down(m_rep_code));
        e_bv = 1'b0;
        e_rv = 1'b0;
        if (gs != 3'd2) begin
            m_blue = 2'b01;
            m_red  = 2'b11;
        end else if (press) begin
            bc = blue_of(v);
            rc = red_of(v);
            if (bc[2] && bc[1:0] != m_blue && bc[1:0] != (m_blue ^ 2'b10)) begin
                m_blue = bc[1:0]; e_bv = 1'b1;
            end
            if (rc[2] && rc[1:0] != m_red && rc[1:0] != (m_red ^ 2'b10)) begin
                m_red = rc[1:0]; e_rv = 1'b1;
            end
        end
        check("keycode_out", keycode_out, e_kc);
        check("enter_pulse", {7'd0, enter_pulse}, {7'd0, e_enter});
        check("up_pulse", {7'd0, up_pulse}, {7'd0, e_up});
        check("down_pulse", {7'd0, down_pulse}, {7'd0, e_down});
        check("blue_dir", {6'd0, blue_dir}, {6'd0, m_blue});
        check("blue_dir_valid", {7'd0, blue_dir_valid}, {7'd0, e_bv});
        check("red_dir", {6'd0, red_dir}, {6'd0, m_red});
        check("red_dir_valid", {7'd0, red_dir_valid}, {7'd0, e_rv});
        step_idx++;
        if (enter_pulse) n_enter++;
        if (keycode_out != 8'h00) n_kc++;
        if (blue_dir_valid) n_bvalid++;
        if (red_dir_valid) n_rvalid++;
        if (up_pulse) begin
            n_up++;
            if (first_up < 0) first_up = step_idx;
        end
    endtask

    task automatic hold(input logic [7:0] kc, input logic [2:0] gs, input int n);
        for (int i = 0; i < n; i++) step(kc, gs);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("reset_keycode_out", keycode_out, 8'h00);
        check("reset_pulses", {5'd0, enter_pulse, up_pulse, down_pulse}, 8'h00);
        check("reset_valids", {6'd0, blue_dir_valid, red_dir_valid}, 8'h00);
        check("reset_blue_dir", {6'd0, blue_dir}, 8'h01);
        check("reset_red_dir", {6'd0, red_dir}, 8'h03);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] rkc;
        logic [2:0] rgs;
        int         rlen;
        Reset      = 1'b0;
        keycode    = 8'h00;
        Game_State = 3'd0;
        model_reset();
        zero_counts();
        #2;
        do_reset();
        hold(8'h00, 3'd0, 5);

        // Enter held: exactly one enter and one keycode strobe, no repeat
        zero_counts();
        hold(8'h28, 3'd0, 30);
        check_cnt("enter_count", n_enter, 1);
        check_cnt("enter_kc_count", n_kc, 1);
        hold(8'h00, 3'd0, 10);

        // Bouncing enter never settles
        zero_counts();
        for (int i = 0; i < 5; i++) begin
            hold(8'h28, 3'd0, 2);
            hold(8'h00, 3'd0, 2);
        end
        hold(8'h00, 3'd0, 10);
        check_cnt("bounce_kc_count", n_kc, 0);
        check_cnt("bounce_enter_count", n_enter, 0);

        // Up arrow held: press at +5 then repeats at +25,+33,+41,+49,+57
        zero_counts();
        hold(8'h52, 3'd0, 60);
        check_cnt("up_repeat_count", n_up, 6);
        check_cnt("first_up_step", first_up, 5);
        hold(8'h00, 3'd0, 30);
        check_cnt("up_after_release", n_up, 6);

        // Blue reverse is dropped, a legal turn is taken
        zero_counts();
        hold(8'h00, 3'd2, 5);
        hold(8'h04, 3'd2, 10);
        check("blue_after_reverse", {6'd0, blue_dir}, 8'h01);
        check_cnt("blue_reverse_valids", n_bvalid, 0);
        hold(8'h00, 3'd2, 8);
        hold(8'h16, 3'd2, 10);
        check("blue_after_down", {6'd0, blue_dir}, 8'h02);
        check_cnt("blue_down_valids", n_bvalid, 1);

        // Directions gated by game state
        hold(8'h00, 3'd0, 8);
        zero_counts();
        hold(8'h07, 3'd0, 10);
        check("blue_menu_dir", {6'd0, blue_dir}, 8'h01);
        check_cnt("blue_menu_valids", n_bvalid, 0);
        hold(8'h00, 3'd0, 8);
        hold(8'h51, 3'd2, 10);
        check("red_after_down", {6'd0, red_dir}, 8'h02);
        check_cnt("red_down_valids", n_rvalid, 1);
        hold(8'h51, 3'd1, 3);
        check("red_paused_dir", {6'd0, red_dir}, 8'h03);

        // Reset during auto-repeat, then a fresh press after release
        hold(8'h00, 3'd0, 10);
        hold(8'h52, 3'd0, 40);
        do_reset();
        zero_counts();
        hold(8'h52, 3'd0, 10);
        check_cnt("post_reset_first_up", first_up, 5);
        check_cnt("post_reset_up_count", n_up, 1);
        hold(8'h00, 3'd0, 10);

        // Random key sequences with mixed game states
        for (int seg = 0; seg < 150; seg++) begin
            rkc  = kc_tab[$urandom_range(0, 10)];
            rlen = ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 7));
            rgs  = ($urandom_range(0, 2) != 0) ? 3'd2 : 3'($urandom_range(0, 4));
            hold(rkc, rgs, rlen);
            if ($urandom_range(0, 40) == 0) do_reset();
        end
        hold(8'h00, 3'd0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits between the USB keyboard keycode register and the game state machine and bike controllers.
- Debounces the raw 8-bit keycode and converts it into single-cycle press events: enter, menu up/down with auto-repeat, and per-player direction commands.
- Emits a press-strobed keycode, so downstream `keycode == 8'h28` compares fire exactly once per physical press.
- Filters illegal 180-degree turns and gates direction commands on the current game state.

Parameters:
- STABLE_CYCLES, 500000, cycles a new keycode must hold before it is accepted (10 ms @ 50 MHz).
- REPEAT_DELAY, 25000000, cycles after an accepted up/down press before the first auto-repeat.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeats.
- BLUE_INIT_DIR, 2'b01, blue bike's starting direction (right).
- RED_INIT_DIR, 2'b11, red bike's starting direction (left).
- CNT_W, 25, width of the internal counters; must hold max(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- keycode  in  8  raw keycode from the keyboard interface; 8'h00 means no key
- Game_State  in  3  current game state: 0 Menu, 1 Round_Paused, 2 Round_Started, 3 Blue_Wins, 4 Red_Wins
- keycode_out  out  8  accepted keycode for one cycle on a press event, 8'h00 otherwise
- enter_pulse  out  1  one-cycle pulse on an accepted 8'h28 press
- up_pulse  out  1  press or repeat of 8'h1A (W) or 8'h52 (Up arrow)
- down_pulse  out  1  press or repeat of 8'h16 (S) or 8'h51 (Down arrow)
- blue_dir  out  2  blue bike's current direction: 00 up, 01 right, 10 down, 11 left
- blue_dir_valid  out  1  one-cycle strobe when blue_dir changes
- red_dir  out  2  red bike's current direction, same encoding as blue_dir
- red_dir_valid  out  1  one-cycle strobe when red_dir changes

Behaviour:
- Reset (async, any cycle): all pulses, valids and keycode_out go to 0; blue_dir = BLUE_INIT_DIR; red_dir = RED_INIT_DIR; counters are cleared; FSM returns to IDLE; accepted code = 00. Reset mid-debounce or mid-repeat discards that activity.
- Input stage: keycode is registered once into kc_q. All decisions use kc_q.
- FSM states and transitions:
  - IDLE: kc_q != accepted → load candidate, clear counter, go to DEBOUNCE.
  - DEBOUNCE:
    - kc_q != candidate → reload candidate, clear counter, stay.
    - Counter reaches STABLE_CYCLES-1 → accepted <= candidate.
    - If candidate != 0: fire press event; go to PRESSED if candidate is up/down, else HELD.
    - If candidate == 0 (release): no event, go to IDLE.
  - HELD: kc_q != accepted → DEBOUNCE. A key change without an intervening release counts as a new press.
  - PRESSED: counter counts up to REPEAT_DELAY-1, then fires a repeat pulse and goes to REPEATING. kc_q != accepted → DEBOUNCE.
  - REPEATING: fires a repeat pulse every REPEAT_PERIOD cycles. kc_q != accepted → DEBOUNCE.
- Latency: if keycode becomes K at edge t and stays stable, the press event outputs are high for exactly one cycle at edge t+1+STABLE_CYCLES.
- Repeats: only up_pulse and down_pulse repeat. Enter, keycode_out and direction strobes never repeat.
- Directions:
  - Blue uses W/D/S/A (1A/07/16/04). Red uses the arrows: 52 up, 4F right, 51 down, 50 left.
  - Processed only on a press event while Game_State == 2.
  - A new direction equal to current^2'b10 (reverse) or equal to current is dropped, with no valid strobe.
  - Otherwise the dir register updates and valid pulses in the same cycle as the press event.
- W/S and the Up/Down arrows drive up_pulse/down_pulse in every state, as well as directions in state 2.
- When Game_State != 2: blue_dir and red_dir are held at their INIT values (reloaded every cycle), and no valid strobes are emitted.
- Unrecognised codes: keycode_out still strobes; no other output is affected.

Decomposition:
- Package tron_pkg:
  - keycode localparams: KC_ENTER, KC_W, KC_A, KC_S, KC_D, KC_UP, KC_DOWN, KC_LEFT, KC_RIGHT.
  - dir_t enum (2-bit).
  - game-state encoding constants, shared with the game state machine.
- One sub-module, key_debounce: input register, candidate/counter logic, accepted code, and the press strobe.
- The repeat FSM and direction filtering stay in the top level.

Test Plan (bench overrides STABLE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- keycode=28 held 30 cycles, Game_State=0 → enter_pulse and keycode_out=28 high exactly 1 cycle, 5 edges after the input change; no repeat.
- keycode toggles 28/00 every 2 cycles for 20 cycles, then 00 → no outputs ever asserted.
- keycode=52 held 60 cycles → up_pulse at +5, then at +25, +33, +41, +49, +57; release → no further pulses.
- Game_State=2, blue_dir=01, press 04 (left, reverse) → blue_dir stays 01, no valid; then press 16 → blue_dir=10 and blue_dir_valid for 1 cycle.
- Game_State=0, press 07 → blue_dir=01 and blue_dir_valid=0; set Game_State=2, press 51 → red_dir=10 and red_dir_valid=1; then Game_State=1 → red_dir returns to 11.
- Reset asserted mid-REPEATING with 52 held → all outputs 0 and dirs at INIT immediately; after release, a new up_pulse appears 5 cycles later.
